// File: rtl/riscv_pkg.sv
// Shared RV32 front-end constants and the fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Fetch targets are word aligned; the two low bits of a target are discarded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold under stall, drain or flush.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  // Flush outranks load; drain only clears the valid bit, data fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, PC register and IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  output logic                imem_rsp_ready,
  input  logic [XLEN-1:0]     imem_rsp_data,
  input  logic                stall_id,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                ifid_valid,
  output logic [XLEN-1:0]     ifid_pc,
  output logic [XLEN-1:0]     ifid_instr,
  output logic [OPCODE_W-1:0] ifid_opcode
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            can_load_s;
  logic            rsp_hs_s;
  logic            ifid_load_s;

  assign can_load_s  = !ifid_valid || !stall_id;
  assign rsp_hs_s    = imem_rsp_valid && imem_rsp_ready;
  // A response that meets a redirect is consumed but never written to IF/ID.
  assign ifid_load_s = (state_q == FETCH_WAIT) && rsp_hs_s && !redirect_valid;

  // Handshake outputs decode from state and are forced low throughout reset.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH_REQ:  imem_req_valid = 1'b1;
        FETCH_WAIT: imem_rsp_ready = redirect_valid || can_load_s;
        FETCH_DROP: imem_rsp_ready = 1'b1;
        default: begin
          imem_req_valid = 1'b0;
          imem_rsp_ready = 1'b0;
        end
      endcase
    end else begin
      imem_req_valid = 1'b0;
      imem_rsp_ready = 1'b0;
    end
  end

  // Fetch FSM and PC; a redirect always wins the PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (ifid_load_s) begin
        pc_q <= pc_q + 32'd4;
      end
      case (state_q)
        FETCH_REQ: begin
          if (imem_req_ready) begin
            state_q <= redirect_valid ? FETCH_DROP : FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (rsp_hs_s) begin
            state_q <= FETCH_REQ;
          end else if (redirect_valid) begin
            state_q <= FETCH_DROP;
          end
        end
        FETCH_DROP: begin
          if (imem_rsp_valid) begin
            state_q <= FETCH_REQ;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .load_i  (ifid_load_s),
    .drain_i (!stall_id),
    .pc_i    (pc_q),
    .instr_i (imem_rsp_data),
    .valid_o (ifid_valid),
    .pc_o    (ifid_pc),
    .instr_o (ifid_instr)
  );

  assign ifid_opcode = ifid_instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: behavioural memory, expected-fetch queue and IF/ID monitor.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [6:0]  ifid_opcode;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_opcode    (ifid_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected IF/ID entries {pc, instr} in fetch order.
  logic [63:0] exp_q[$];

  // Memory and fetch-PC model state.
  logic [31:0] model_pc  = 32'h0;
  bit          mem_busy  = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  int          mem_wait  = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          acc       = 1'b0;
  logic [31:0] acc_addr  = 32'h0;

  // Monitor's view of what IF/ID should hold.
  bit          cur_valid = 1'b0;
  logic [31:0] cur_pc    = 32'h0;
  logic [31:0] cur_instr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:2], 7'h33 ^ {2'b00, a[6:2]}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, then check and update the model just before the edge.
  task automatic step(input logic r, input logic rdy, input logic stl, input logic rv,
                      input logic [31:0] rpc);
    @(negedge clk);
    rst            = r;
    imem_req_ready = rdy;
    stall_id       = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (mem_busy && mem_wait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_busy) mem_wait--;
    end
    #2;
    acc = 1'b0;
    if (r) begin
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
      mem_busy = 1'b0;
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      if (imem_req_valid) begin
        chk("req_addr", imem_addr, model_pc);
        chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
      end
      if (ifid_valid && stl && !rv)
        chk("stall_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
      if (imem_rsp_valid && imem_rsp_ready) mem_busy = 1'b0;
      if (imem_req_valid && rdy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = $urandom_range(lat_max, lat_min) - 1;
        acc      = 1'b1;
        acc_addr = imem_addr;
        if (!rv) begin
          exp_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
      if (rv) begin
        exp_q.delete();
        model_pc = rpc & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Step with ready=1 until a request is accepted; optionally check its address.
  task automatic wait_acc(input string name, input bit do_check, input logic [31:0] exp_addr);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      if (acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no request accepted within 20 cycles", name);
    end else if (do_check) begin
      chk(name, acc_addr, exp_addr);
    end
  endtask

  // Monitor: after every edge, compare IF/ID against the expected entry stream.
  initial begin
    bit p_rst, p_redir, p_hold;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      p_rst   = rst;
      p_redir = redirect_valid;
      p_hold  = cur_valid && stall_id && !redirect_valid;
      @(posedge clk);
      #1;
      if (p_rst) begin
        chk("reset_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("reset_ifid_pc", ifid_pc, 32'h0);
        chk("reset_ifid_instr", ifid_instr, 32'h0000_0013);
        chk("reset_ifid_opcode", {25'd0, ifid_opcode}, 32'h13);
        cur_valid = 1'b0;
      end else if (p_redir) begin
        chk("redirect_flush", {31'd0, ifid_valid}, 32'd0);
        cur_valid = 1'b0;
      end else if (p_hold) begin
        chk("hold_valid", {31'd0, ifid_valid}, 32'd1);
        chk("hold_pc", ifid_pc, cur_pc);
        chk("hold_instr", ifid_instr, cur_instr);
      end else if (ifid_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_load: got pc %h with no fetch expected", ifid_pc);
        end else begin
          e = exp_q.pop_front();
          chk("load_pc", ifid_pc, e[63:32]);
          chk("load_instr", ifid_instr, e[31:0]);
          chk("load_opcode", {25'd0, ifid_opcode}, {25'd0, e[6:0]});
          cur_valid = 1'b1;
          cur_pc    = e[63:32];
          cur_instr = e[31:0];
        end
      end else begin
        cur_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus: directed scenarios followed by a randomized run and a drain.
  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    lat_min = 1;
    lat_max = 1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Zero-wait memory after reset release: IF/ID fills two cycles after the first request.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, 32'h0);
    @(posedge clk);
    #2;
    chk("ifid_not_yet", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    chk("ifid_latency2", {31'd0, ifid_valid}, 32'd1);
    chk("first_opcode", {25'd0, ifid_opcode}, 32'h33);
    wait_acc("addr_4", 1'b1, 32'h4);
    wait_acc("addr_8", 1'b1, 32'h8);

    // Decode stall with a response pending, then release.
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect while waiting, response arrives two cycles later and is dropped.
    lat_min = 3;
    lat_max = 3;
    wait_acc("pre_redirect", 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
    lat_min = 1;
    lat_max = 1;
    wait_acc("redirect_wait_addr", 1'b1, 32'h100);

    // Redirect coinciding with the response.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("redirect_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
    wait_acc("redirect_rsp_addr", 1'b1, 32'h200);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    wait_acc("wrap_top", 1'b1, 32'hFFFF_FFFC);
    wait_acc("wrap_zero", 1'b1, 32'h0);

    // Reset while a response is outstanding.
    lat_min = 2;
    lat_max = 2;
    wait_acc("pre_reset", 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("midrst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    chk("midrst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("midrst_ifid_instr", ifid_instr, 32'h0000_0013);
    lat_min = 1;
    lat_max = 1;
    wait_acc("restart_addr", 1'b1, 32'h0);

    // Randomized traffic.
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      logic        rdy, stl, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(9, 0) < 7);
      stl = ($urandom_range(9, 0) < 3);
      rv  = ($urandom_range(19, 0) == 0);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      step(1'b0, rdy, stl, rv, rpc);
    end

    // Drain: no new requests accepted, every expected fetch must have reached IF/ID.
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
